// File: rtl/fifo_level_if.sv
// ============================================================================
//  Module      : fifo_level_if
//  Description : Handshake bundle between a fifo_level buffer and its user.
//                Signal directions in the names are from the FIFO's point of
//                view: i_* flow into the FIFO, o_* flow out of it.
//  Ports       : i_data_w / i_write_w   push side
//                i_read_w               pop / head acknowledge
//                o_data_w / o_valid_w   read data and its qualifier
//                o_full_w, o_empty_w, o_almost_full_w, o_almost_empty_w,
//                o_fill_w, o_overflow_w, o_underflow_w   status
//  Modports    : slave  - the FIFO itself
//                master - the block that pushes and pops
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fifo_level_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
);

  logic [FIFO_WIDTH-1:0] i_data_w;
  logic                  i_write_w;
  logic                  i_read_w;
  logic [FIFO_WIDTH-1:0] o_data_w;
  logic                  o_valid_w;
  logic                  o_full_w;
  logic                  o_empty_w;
  logic                  o_almost_full_w;
  logic                  o_almost_empty_w;
  logic [FIFO_DEPTH:0]   o_fill_w;
  logic                  o_overflow_w;
  logic                  o_underflow_w;

  modport slave (
    input  i_data_w, i_write_w, i_read_w,
    output o_data_w, o_valid_w, o_full_w, o_empty_w,
           o_almost_full_w, o_almost_empty_w, o_fill_w,
           o_overflow_w, o_underflow_w
  );

  modport master (
    output i_data_w, i_write_w, i_read_w,
    input  o_data_w, o_valid_w, o_full_w, o_empty_w,
           o_almost_full_w, o_almost_empty_w, o_fill_w,
           o_overflow_w, o_underflow_w
  );

endinterface

`default_nettype wire

// File: rtl/fifo_level.sv
// ============================================================================
//  Module      : fifo_level
//  Description : Single-clock FIFO with 2^FIFO_DEPTH usable entries, fill
//                level, programmable almost-full / almost-empty flags, sticky
//                overflow / underflow errors and an optional first-word-fall-
//                through read mode.
//  Ports       : i_clk      - clock, all logic on the rising edge
//                i_reset_w  - synchronous active-high reset
//                bus        - fifo_level_if.slave (data, handshake, status)
//  Note        : the interface instance must use the same FIFO_WIDTH and
//                FIFO_DEPTH as this module.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_level #(
  parameter int FIFO_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_LVL  = (2**FIFO_DEPTH) - 1,
  parameter int ALMOST_EMPTY_LVL = 1
) (
  input  logic         i_clk,
  input  logic         i_reset_w,
  fifo_level_if.slave  bus
);

  localparam int c_CAPACITY = 2**FIFO_DEPTH;

  // Thresholds are legal in 0..capacity, which always fits in FIFO_DEPTH+1 bits.
  localparam logic [FIFO_DEPTH:0] c_AF_LVL = (FIFO_DEPTH+1)'(ALMOST_FULL_LVL);
  localparam logic [FIFO_DEPTH:0] c_AE_LVL = (FIFO_DEPTH+1)'(ALMOST_EMPTY_LVL);

  localparam bit c_LVL_OK = (ALMOST_FULL_LVL  >= 0) && (ALMOST_FULL_LVL  <= c_CAPACITY) &&
                            (ALMOST_EMPTY_LVL >= 0) && (ALMOST_EMPTY_LVL <= c_CAPACITY);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Pointers carry one extra MSB so that full and empty are distinguishable
  // with every entry in use.
  logic [FIFO_DEPTH:0]   r_wr_ptr;
  logic [FIFO_DEPTH:0]   r_rd_ptr;
  logic [FIFO_WIDTH-1:0] r_mem [0:c_CAPACITY-1];
  logic                  r_overflow;
  logic                  r_underflow;

  logic [FIFO_DEPTH-1:0] w_wr_addr;
  logic [FIFO_DEPTH-1:0] w_rd_addr;
  logic [FIFO_DEPTH:0]   w_fill;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;

  assign w_wr_addr = r_wr_ptr[FIFO_DEPTH-1:0];
  assign w_rd_addr = r_rd_ptr[FIFO_DEPTH-1:0];

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_wr_addr == w_rd_addr) &&
                   (r_wr_ptr[FIFO_DEPTH] != r_rd_ptr[FIFO_DEPTH]);
  // Modular subtraction gives the level directly, including across wrap.
  assign w_fill  = r_wr_ptr - r_rd_ptr;

  // A pop frees a slot in the same edge, so a full FIFO still accepts a
  // write that is paired with a read. An empty FIFO has no bypass: the
  // paired read is rejected even though the write lands.
  assign w_pop  = bus.i_read_w & ~w_empty;
  assign w_push = bus.i_write_w & (~w_full | w_pop);

  // --------------------------------------------------------------------------
  // Pointers and sticky errors
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset_w) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (bus.i_write_w & ~w_push) begin
        r_overflow <= 1'b1;
      end
      if (bus.i_read_w & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Storage has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_push & ~i_reset_w) begin
      r_mem[w_wr_addr] <= bus.i_data_w;
    end
  end

  // --------------------------------------------------------------------------
  // Read data path
  // --------------------------------------------------------------------------
  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always on the output; valid simply mirrors non-empty.
      assign bus.o_data_w  = r_mem[w_rd_addr];
      assign bus.o_valid_w = ~w_empty;
    end else begin : g_registered
      logic [FIFO_WIDTH-1:0] r_data;
      logic                  r_valid;

      // Data register holds its last value between pops; valid is a
      // one-cycle strobe per accepted pop.
      always_ff @(posedge i_clk) begin
        if (i_reset_w) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_pop;
          if (w_pop) begin
            r_data <= r_mem[w_rd_addr];
          end
        end
      end

      assign bus.o_data_w  = r_data;
      assign bus.o_valid_w = r_valid;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Status outputs (all derived from registered pointers / error bits)
  // --------------------------------------------------------------------------
  assign bus.o_full_w         = w_full;
  assign bus.o_empty_w        = w_empty;
  assign bus.o_fill_w         = w_fill;
  assign bus.o_almost_full_w  = (w_fill >= c_AF_LVL);
  assign bus.o_almost_empty_w = (w_fill <= c_AE_LVL);
  assign bus.o_overflow_w     = r_overflow;
  assign bus.o_underflow_w    = r_underflow;

  // Out-of-range thresholds would silently truncate above; catch them early.
  always_ff @(posedge i_clk) begin
    assert (c_LVL_OK)
      else $error("fifo_level: almost-full/almost-empty threshold outside 0..%0d", c_CAPACITY);
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_level.sv
// ============================================================================
//  Module      : tb_fifo_level
//  Description : Directed self-checking bench for fifo_level. One instance in
//                registered-read mode, one in first-word-fall-through mode.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_level;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  fifo_level_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(4)) if0 ();
  fifo_level_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(4)) if1 ();

  fifo_level #(
    .FIFO_WIDTH(8), .FIFO_DEPTH(4), .FWFT(0),
    .ALMOST_FULL_LVL(15), .ALMOST_EMPTY_LVL(1)
  ) u_dut0 (
    .i_clk     (clk),
    .i_reset_w (rst),
    .bus       (if0.slave)
  );

  fifo_level #(
    .FIFO_WIDTH(8), .FIFO_DEPTH(4), .FWFT(1),
    .ALMOST_FULL_LVL(15), .ALMOST_EMPTY_LVL(1)
  ) u_dut1 (
    .i_clk     (clk),
    .i_reset_w (rst),
    .bus       (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    if0.i_data_w = '0; if0.i_write_w = 1'b0; if0.i_read_w = 1'b0;
    if1.i_data_w = '0; if1.i_write_w = 1'b0; if1.i_read_w = 1'b0;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_empty",   32'(if0.o_empty_w),        32'd1);
    check("rst_full",    32'(if0.o_full_w),         32'd0);
    check("rst_fill",    32'(if0.o_fill_w),         32'd0);
    check("rst_valid",   32'(if0.o_valid_w),        32'd0);
    check("rst_data",    32'(if0.o_data_w),         32'd0);
    check("rst_ae",      32'(if0.o_almost_empty_w), 32'd1);
    check("rst_af",      32'(if0.o_almost_full_w),  32'd0);
    check("rst_ovf",     32'(if0.o_overflow_w),     32'd0);
    check("rst_unf",     32'(if0.o_underflow_w),    32'd0);
    check("rst_valid_f", 32'(if1.o_valid_w),        32'd0);
    rst = 1'b0;

    // ---------------- 1: fill to full, then drain ----------------
    for (int i = 1; i <= 16; i++) begin
      if0.i_data_w = 8'(i); if0.i_write_w = 1'b1;
      step();
      check("t1_fill", 32'(if0.o_fill_w), 32'(i));
      if (i == 1)  check("t1_ae_at1",  32'(if0.o_almost_empty_w), 32'd1);
      if (i == 2)  check("t1_ae_at2",  32'(if0.o_almost_empty_w), 32'd0);
      if (i == 14) check("t1_af_at14", 32'(if0.o_almost_full_w),  32'd0);
      if (i == 15) check("t1_af_at15", 32'(if0.o_almost_full_w),  32'd1);
      if (i == 15) check("t1_full15",  32'(if0.o_full_w),         32'd0);
    end
    if0.i_write_w = 1'b0;
    check("t1_full",  32'(if0.o_full_w),     32'd1);
    check("t1_ovf",   32'(if0.o_overflow_w), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      if0.i_read_w = 1'b1;
      step();
      check("t1_pop_valid", 32'(if0.o_valid_w), 32'd1);
      check("t1_pop_data",  32'(if0.o_data_w),  32'(i));
      if0.i_read_w = 1'b0;
      step();
      check("t1_idle_valid", 32'(if0.o_valid_w), 32'd0);
      check("t1_idle_hold",  32'(if0.o_data_w),  32'(i));
    end
    check("t1_empty", 32'(if0.o_empty_w), 32'd1);
    check("t1_fill0", 32'(if0.o_fill_w),  32'd0);

    // ---------------- 2: full, push and pop together ----------------
    for (int i = 1; i <= 16; i++) begin
      if0.i_data_w = 8'(i); if0.i_write_w = 1'b1;
      step();
    end
    if0.i_data_w = 8'hAA; if0.i_write_w = 1'b1; if0.i_read_w = 1'b1;
    step();
    if0.i_write_w = 1'b0;
    check("t2_fill",  32'(if0.o_fill_w),     32'd16);
    check("t2_full",  32'(if0.o_full_w),     32'd1);
    check("t2_ovf",   32'(if0.o_overflow_w), 32'd0);
    check("t2_data",  32'(if0.o_data_w),     32'h01);
    for (int k = 0; k < 16; k++) begin
      step();
      check("t2_drain", 32'(if0.o_data_w), (k < 15) ? 32'(k + 2) : 32'hAA);
    end
    if0.i_read_w = 1'b0;
    step();
    check("t2_empty", 32'(if0.o_empty_w), 32'd1);

    // ---------------- 3: empty, push and pop together ----------------
    if0.i_data_w = 8'h55; if0.i_write_w = 1'b1; if0.i_read_w = 1'b1;
    step();
    if0.i_write_w = 1'b0;
    check("t3_unf",   32'(if0.o_underflow_w), 32'd1);
    check("t3_fill",  32'(if0.o_fill_w),      32'd1);
    check("t3_valid", 32'(if0.o_valid_w),     32'd0);
    step();
    if0.i_read_w = 1'b0;
    check("t3_valid2", 32'(if0.o_valid_w), 32'd1);
    check("t3_data",   32'(if0.o_data_w),  32'h55);
    check("t3_fill0",  32'(if0.o_fill_w),  32'd0);

    // ---------------- 4: overflow, then reset with a write ----------------
    for (int i = 0; i < 16; i++) begin
      if0.i_data_w = 8'(8'h20 + i); if0.i_write_w = 1'b1;
      step();
    end
    if0.i_data_w = 8'h77;
    step();
    if0.i_write_w = 1'b0;
    check("t4_ovf",  32'(if0.o_overflow_w), 32'd1);
    check("t4_fill", 32'(if0.o_fill_w),     32'd16);
    step();
    check("t4_ovf_sticky", 32'(if0.o_overflow_w), 32'd1);
    for (int k = 0; k < 16; k++) begin
      if0.i_read_w = 1'b1;
      step();
      check("t4_drain", 32'(if0.o_data_w), 32'(8'h20 + k));
    end
    if0.i_read_w = 1'b0;
    step();
    check("t4_empty",   32'(if0.o_empty_w),     32'd1);
    check("t4_unf_sticky", 32'(if0.o_underflow_w), 32'd1);
    rst = 1'b1; if0.i_data_w = 8'h99; if0.i_write_w = 1'b1;
    step();
    rst = 1'b0; if0.i_write_w = 1'b0;
    check("t4_rst_fill",  32'(if0.o_fill_w),      32'd0);
    check("t4_rst_empty", 32'(if0.o_empty_w),     32'd1);
    check("t4_rst_ovf",   32'(if0.o_overflow_w),  32'd0);
    check("t4_rst_unf",   32'(if0.o_underflow_w), 32'd0);
    check("t4_rst_valid", 32'(if0.o_valid_w),     32'd0);

    // ---------------- 5: first-word-fall-through ----------------
    check("t5_idle_valid", 32'(if1.o_valid_w), 32'd0);
    if1.i_data_w = 8'h3C; if1.i_write_w = 1'b1;
    step();
    check("t5_valid", 32'(if1.o_valid_w), 32'd1);
    check("t5_data",  32'(if1.o_data_w),  32'h3C);
    if1.i_data_w = 8'h4D; if1.i_write_w = 1'b1; if1.i_read_w = 1'b1;
    step();
    if1.i_write_w = 1'b0;
    check("t5_valid2", 32'(if1.o_valid_w), 32'd1);
    check("t5_data2",  32'(if1.o_data_w),  32'h4D);
    step();
    if1.i_read_w = 1'b0;
    check("t5_valid3", 32'(if1.o_valid_w), 32'd0);
    check("t5_empty",  32'(if1.o_empty_w), 32'd1);

    // ---------------- 6: pointer wrap with push/pop pairs ----------------
    for (int i = 0; i < 40; i++) begin
      if0.i_data_w = 8'(i); if0.i_write_w = 1'b1;
      step();
      if0.i_write_w = 1'b0;
      check("t6_fill1", 32'(if0.o_fill_w), 32'd1);
      if0.i_read_w = 1'b1;
      step();
      if0.i_read_w = 1'b0;
      check("t6_valid", 32'(if0.o_valid_w), 32'd1);
      check("t6_data",  32'(if0.o_data_w),  32'(i));
      check("t6_fill0", 32'(if0.o_fill_w),  32'd0);
    end
    check("t6_ovf", 32'(if0.o_overflow_w),  32'd0);
    check("t6_unf", 32'(if0.o_underflow_w), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
